// File: rtl/risc32_mem_stage_pkg.sv
// rtl/risc32_mem_stage_pkg.sv - risc32 MEM-stage opcodes, stall indices and FSM states
package risc32_mem_stage_pkg;

    localparam int STALL_W   = 6;
    localparam int STALL_MEM = 4;
    localparam logic NO_STOP   = 1'b0;
    localparam logic WRITE_DIS = 1'b0;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP) || (op == EXE_LL_OP);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP) || (op == EXE_SC_OP);
    endfunction

endpackage

// File: rtl/risc32_mem_align.sv
// rtl/risc32_mem_align.sv - big-endian lane select, load extension and store sel/data
module risc32_mem_align
    import risc32_mem_stage_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    input  logic [31:0] reg2,
    output logic        misalign,
    output logic [3:0]  sel,
    output logic [31:0] store_data,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        // Byte 0 of a word lives in the most significant lane.
        case (addr)
            2'd0:    lane_byte = rdata[31:24];
            2'd1:    lane_byte = rdata[23:16];
            2'd2:    lane_byte = rdata[15:8];
            default: lane_byte = rdata[7:0];
        endcase
        lane_half = addr[1] ? rdata[15:0] : rdata[31:16];

        misalign   = 1'b0;
        sel        = 4'b0000;
        store_data = 32'd0;
        load_data  = 32'd0;
        case (aluop)
            EXE_LB_OP:  begin sel = 4'b1000 >> addr; load_data = {{24{lane_byte[7]}}, lane_byte}; end
            EXE_LBU_OP: begin sel = 4'b1000 >> addr; load_data = {24'd0, lane_byte}; end
            EXE_LH_OP:  begin misalign = addr[0]; sel = addr[1] ? 4'b0011 : 4'b1100;
                              load_data = {{16{lane_half[15]}}, lane_half}; end
            EXE_LHU_OP: begin misalign = addr[0]; sel = addr[1] ? 4'b0011 : 4'b1100;
                              load_data = {16'd0, lane_half}; end
            EXE_LW_OP, EXE_LL_OP: begin
                misalign  = (addr != 2'd0);
                sel       = 4'b1111;
                load_data = rdata;
            end
            EXE_SB_OP:  begin sel = 4'b1000 >> addr; store_data = {4{reg2[7:0]}}; end
            EXE_SH_OP:  begin misalign = addr[0]; sel = addr[1] ? 4'b0011 : 4'b1100;
                              store_data = {2{reg2[15:0]}}; end
            EXE_SW_OP, EXE_SC_OP: begin
                misalign   = (addr != 2'd0);
                sel        = 4'b1111;
                store_data = reg2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/risc32_mem_stage.sv
// rtl/risc32_mem_stage.sv - risc32 MEM stage: bus loads/stores, LL/SC link bit, stall request
module risc32_mem_stage
    import risc32_mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    input  logic              whilo_i,
    input  logic              cp0_reg_we_i,
    input  logic [4:0]        cp0_reg_write_addr_i,
    input  logic [31:0]       cp0_reg_data_i,
    input  logic [7:0]        aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic              llbit_clear_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              whilo_o,
    output logic              cp0_reg_we_o,
    output logic [4:0]        cp0_reg_write_addr_o,
    output logic [31:0]       cp0_reg_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              stallreq_o,
    output logic              misalign_o
);

    mem_state_t  state, state_next;
    logic        llbit, llbit_next;
    logic [31:0] rdata_q;
    logic        misalign, access, advance, stallreq, is_sc, held;
    logic [3:0]  sel;
    logic [31:0] store_data, load_data;
    logic        unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};
    assign held  = (stall[STALL_MEM] != NO_STOP);
    assign is_sc = (aluop_i == EXE_SC_OP);

    risc32_mem_align u_align (
        .aluop      (aluop_i),
        .addr       (mem_addr_i[1:0]),
        .rdata      ((state == MEM_DONE) ? rdata_q : mem_rdata_i),
        .reg2       (reg2_i),
        .misalign   (misalign),
        .sel        (sel),
        .store_data (store_data),
        .load_data  (load_data)
    );

    // Once in WAIT the access is committed, even an SC whose link is cleared mid-flight.
    always_comb begin
        case (state)
            MEM_IDLE: access = (is_load_op(aluop_i) || is_store_op(aluop_i)) && !misalign &&
                               !(is_sc && !llbit);
            MEM_WAIT: access = 1'b1;
            default:  access = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        stallreq   = 1'b0;
        advance    = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (access && !mem_ack_i) begin
                    state_next = MEM_WAIT;
                    stallreq   = 1'b1;
                end else begin
                    advance = !held;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_next = held ? MEM_DONE : MEM_IDLE;
                    advance    = !held;
                end else begin
                    stallreq = 1'b1;
                end
            end
            MEM_DONE: begin
                if (!held) begin
                    state_next = MEM_IDLE;
                    advance    = 1'b1;
                end
            end
            default: state_next = MEM_IDLE;
        endcase
    end

    always_comb begin
        llbit_next = llbit;
        if (advance && (aluop_i == EXE_LL_OP) && !misalign)
            llbit_next = 1'b1;
        if ((advance && is_sc) || llbit_clear_i)
            llbit_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= MEM_IDLE;
            llbit   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_next;
            llbit <= llbit_next;
            if (state == MEM_WAIT && mem_ack_i && held)
                rdata_q <= mem_rdata_i;
        end
    end

    always_comb begin
        wd_o                 = wd_i;
        wreg_o               = wreg_i && !misalign;
        wdata_o              = wdata_i;
        hi_o                 = hi_i;
        lo_o                 = lo_i;
        whilo_o              = whilo_i;
        cp0_reg_we_o         = cp0_reg_we_i;
        cp0_reg_write_addr_o = cp0_reg_write_addr_i;
        cp0_reg_data_o       = cp0_reg_data_i;
        mem_req_o            = access;
        mem_we_o             = access && is_store_op(aluop_i);
        mem_addr_o           = access ? mem_addr_i[ADDR_W-1:0] : '0;
        mem_sel_o            = access ? sel : 4'b0000;
        mem_wdata_o          = access ? store_data : 32'd0;
        stallreq_o           = stallreq;
        misalign_o           = misalign;
        if (is_load_op(aluop_i))
            wdata_o = load_data;
        else if (is_sc)
            wdata_o = (state == MEM_IDLE) ? {31'd0, llbit} : 32'd1;
        if (!rst) begin
            wd_o                 = 5'd0;
            wreg_o               = WRITE_DIS;
            wdata_o              = 32'd0;
            hi_o                 = 32'd0;
            lo_o                 = 32'd0;
            whilo_o              = WRITE_DIS;
            cp0_reg_we_o         = WRITE_DIS;
            cp0_reg_write_addr_o = 5'd0;
            cp0_reg_data_o       = 32'd0;
            mem_req_o            = 1'b0;
            mem_we_o             = 1'b0;
            mem_addr_o           = '0;
            mem_sel_o            = 4'b0000;
            mem_wdata_o          = 32'd0;
            stallreq_o           = 1'b0;
            misalign_o           = 1'b0;
        end
    end

endmodule

// File: tb/tb_risc32_mem_stage.sv
// tb/tb_risc32_mem_stage.sv - directed self-checking bench for risc32_mem_stage
module tb_risc32_mem_stage;
    import risc32_mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  wd_i, wd_o, cp0_reg_write_addr_i, cp0_reg_write_addr_o;
    logic        wreg_i, wreg_o, whilo_i, whilo_o, cp0_reg_we_i, cp0_reg_we_o;
    logic [31:0] wdata_i, wdata_o, hi_i, hi_o, lo_i, lo_o, cp0_reg_data_i, cp0_reg_data_o;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        llbit_clear_i, mem_req_o, mem_we_o, mem_ack_i, stallreq_o, misalign_o;
    logic [3:0]  mem_sel_o;

    int passed = 0;
    int total  = 0;
    int stall_cycles;

    localparam logic [7:0] NOP_OP = 8'b0010_0001;

    risc32_mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
        .cp0_reg_we_i(cp0_reg_we_i), .cp0_reg_write_addr_i(cp0_reg_write_addr_i),
        .cp0_reg_data_i(cp0_reg_data_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .llbit_clear_i(llbit_clear_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
        .cp0_reg_we_o(cp0_reg_we_o), .cp0_reg_write_addr_o(cp0_reg_write_addr_o),
        .cp0_reg_data_o(cp0_reg_data_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stallreq_o(stallreq_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [7:0] a, input logic [31:0] addr, input logic [31:0] r2,
                      input logic [31:0] rd, input logic ack);
        aluop_i     = a;
        mem_addr_i  = addr;
        reg2_i      = r2;
        mem_rdata_i = rd;
        mem_ack_i   = ack;
        #3;
    endtask

    initial begin
        rst = 1'b0; stall = 6'd0;
        wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h5555_AAAA;
        hi_i = 32'h1111_0000; lo_i = 32'h0000_2222; whilo_i = 1'b1;
        cp0_reg_we_i = 1'b1; cp0_reg_write_addr_i = 5'd12; cp0_reg_data_i = 32'hC0C0_0001;
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h100; reg2_i = 32'd0;
        llbit_clear_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        #3;
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
        check("rst_wreg", {31'd0, wreg_o}, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_llbit", {31'd0, dut.llbit}, 32'd0);

        tick(); rst = 1'b1;
        // pass-through of a non-memory op
        op(NOP_OP, 32'h100, 32'd0, 32'd0, 1'b1);
        check("nop_wdata", wdata_o, 32'h5555_AAAA);
        check("nop_hi", hi_o, 32'h1111_0000);
        check("nop_cp0", cp0_reg_data_o, 32'hC0C0_0001);
        check("nop_wd", {27'd0, wd_o}, 32'd3);
        check("nop_req", {31'd0, mem_req_o}, 32'd0);
        check("nop_stallreq", {31'd0, stallreq_o}, 32'd0);

        // LW zero-wait
        tick(); op(EXE_LW_OP, 32'h100, 32'd0, 32'hDEAD_BEEF, 1'b1);
        check("lw_req", {31'd0, mem_req_o}, 32'd1);
        check("lw_we", {31'd0, mem_we_o}, 32'd0);
        check("lw_sel", {28'd0, mem_sel_o}, 32'hF);
        check("lw_addr", mem_addr_o, 32'h100);
        check("lw_wdata", wdata_o, 32'hDEAD_BEEF);
        check("lw_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick();
        check("lw_state", 32'(dut.state), 32'(MEM_IDLE));

        // LB with ack in the fourth request cycle: three stall cycles
        op(EXE_LB_OP, 32'h101, 32'd0, 32'h1280_FF00, 1'b0);
        stall_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_ack_i = 1'b1; #1; end
            if (stallreq_o) stall_cycles++;
            if (i == 3) begin
                check("lb_wdata", wdata_o, 32'hFFFF_FF80);
                check("lb_sel", {28'd0, mem_sel_o}, 32'h4);
            end
            tick();
            mem_ack_i = 1'b0;
            #3;
        end
        check("lb_stall_cycles", stall_cycles, 32'd3);
        aluop_i = NOP_OP;
        tick(); op(EXE_LBU_OP, 32'h101, 32'd0, 32'h1280_FF00, 1'b1);
        check("lbu_wdata", wdata_o, 32'h0000_0080);

        // SH replicated across lanes, one wait cycle
        tick(); op(EXE_SH_OP, 32'h202, 32'h0000_ABCD, 32'd0, 1'b0);
        check("sh_sel", {28'd0, mem_sel_o}, 32'h3);
        check("sh_wdata", mem_wdata_o, 32'hABCD_ABCD);
        check("sh_we", {31'd0, mem_we_o}, 32'd1);
        check("sh_stallreq0", {31'd0, stallreq_o}, 32'd1);
        tick(); #3;
        check("sh_wait_req", {31'd0, mem_req_o}, 32'd1);
        check("sh_wait_addr", mem_addr_o, 32'h202);
        mem_ack_i = 1'b1; #1;
        check("sh_ack_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick(); op(NOP_OP, 32'd0, 32'd0, 32'd0, 1'b0);

        // LL then SC succeeds
        tick(); op(EXE_LL_OP, 32'h300, 32'd0, 32'hCAFE_F00D, 1'b1);
        check("ll_wdata", wdata_o, 32'hCAFE_F00D);
        tick(); op(NOP_OP, 32'd0, 32'd0, 32'd0, 1'b0);
        check("ll_llbit", {31'd0, dut.llbit}, 32'd1);
        tick(); op(EXE_SC_OP, 32'h300, 32'h77, 32'd0, 1'b1);
        check("sc_req", {31'd0, mem_req_o}, 32'd1);
        check("sc_we", {31'd0, mem_we_o}, 32'd1);
        check("sc_mwdata", mem_wdata_o, 32'h77);
        check("sc_wdata", wdata_o, 32'd1);
        tick(); op(NOP_OP, 32'd0, 32'd0, 32'd0, 1'b0);
        check("sc_llbit", {31'd0, dut.llbit}, 32'd0);

        // LL, clear, then SC fails
        op(EXE_LL_OP, 32'h300, 32'd0, 32'h1, 1'b1);
        tick(); llbit_clear_i = 1'b1; op(NOP_OP, 32'd0, 32'd0, 32'd0, 1'b0);
        tick(); llbit_clear_i = 1'b0;
        op(EXE_SC_OP, 32'h300, 32'h77, 32'd0, 1'b0);
        check("scf_req", {31'd0, mem_req_o}, 32'd0);
        check("scf_wdata", wdata_o, 32'd0);
        check("scf_stallreq", {31'd0, stallreq_o}, 32'd0);

        // misaligned word load
        tick(); op(EXE_LW_OP, 32'h102, 32'd0, 32'd0, 1'b1);
        check("mis_flag", {31'd0, misalign_o}, 32'd1);
        check("mis_req", {31'd0, mem_req_o}, 32'd0);
        check("mis_wreg", {31'd0, wreg_o}, 32'd0);

        // LH completes while MEM is held: result comes from the captured word
        tick(); op(EXE_LH_OP, 32'h206, 32'd0, 32'd0, 1'b0);
        tick(); stall = 6'b010000; mem_rdata_i = 32'h1234_8001; mem_ack_i = 1'b1; #3;
        tick(); mem_ack_i = 1'b1; mem_rdata_i = 32'd0; #3;
        check("done_state", 32'(dut.state), 32'(MEM_DONE));
        check("done_wdata", wdata_o, 32'hFFFF_8001);
        check("done_req", {31'd0, mem_req_o}, 32'd0);
        check("done_stallreq", {31'd0, stallreq_o}, 32'd0);
        mem_ack_i = 1'b0; stall = 6'd0;
        tick(); op(NOP_OP, 32'd0, 32'd0, 32'd0, 1'b0);
        check("done_exit", 32'(dut.state), 32'(MEM_IDLE));

        // SC in WAIT with ack and clear together
        op(EXE_LL_OP, 32'h300, 32'd0, 32'd0, 1'b1);
        tick(); op(EXE_SC_OP, 32'h300, 32'h99, 32'd0, 1'b0);
        tick(); llbit_clear_i = 1'b1; mem_ack_i = 1'b1; #3;
        check("scw_req", {31'd0, mem_req_o}, 32'd1);
        check("scw_wdata", wdata_o, 32'd1);
        tick(); llbit_clear_i = 1'b0; op(NOP_OP, 32'd0, 32'd0, 32'd0, 1'b0);
        check("scw_llbit", {31'd0, dut.llbit}, 32'd0);

        // reset during WAIT
        op(EXE_LL_OP, 32'h300, 32'd0, 32'd0, 1'b1);
        tick(); op(EXE_LW_OP, 32'h400, 32'd0, 32'd0, 1'b0);
        tick(); #2;
        check("rw_wait", 32'(dut.state), 32'(MEM_WAIT));
        rst = 1'b0; #1;
        check("rw_state", 32'(dut.state), 32'(MEM_IDLE));
        check("rw_req", {31'd0, mem_req_o}, 32'd0);
        check("rw_llbit", {31'd0, dut.llbit}, 32'd0);
        tick(); rst = 1'b1;
        op(EXE_LW_OP, 32'h400, 32'd0, 32'h0BAD_F00D, 1'b1);
        check("rw_next_req", {31'd0, mem_req_o}, 32'd1);
        check("rw_next_wdata", wdata_o, 32'h0BAD_F00D);
        check("rw_next_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/risc32_mem_stage.md
# risc32_mem_stage

Memory-access stage of the five-stage risc32 pipeline. It sits between the EX/MEM pipeline register and `risc32_mem_wb`, and it produces every `*_i` input that `risc32_mem_wb` latches. It performs byte/halfword/word loads and stores over a req/ack data bus and owns the LL/SC link bit. It raises a stall request while a bus access is outstanding.

## Interface
Parameters:
- `ADDR_W`, default 32: data-bus address width.

Ports (widths from `risc32_consts.v`):
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low (asserted at 0).
- `stall` in `Stall_Bus` (6): pipeline stall vector; `stall[4]` = MEM stage held.
- `wd_i` in 5, `wreg_i` in 1, `wdata_i` in 32: EX result and destination.
- `hi_i` in 32, `lo_i` in 32, `whilo_i` in 1: HI/LO writeback.
- `cp0_reg_we_i` in 1, `cp0_reg_write_addr_i` in 5, `cp0_reg_data_i` in 32: CP0 writeback.
- `aluop_i` in 8: operation code; memory ops are LB, LBU, LH, LHU, LW, LL, SB, SH, SW, SC.
- `mem_addr_i` in 32: effective address.
- `reg2_i` in 32: store data.
- `llbit_clear_i` in 1: clears the link bit (ERET/exception).
- `wd_o` out 5, `wreg_o` out 1, `wdata_o` out 32, `hi_o`/`lo_o` out 32, `whilo_o` out 1, `cp0_*_o`: outputs to `risc32_mem_wb`.
- `mem_req_o` out 1, `mem_we_o` out 1, `mem_addr_o` out `ADDR_W`, `mem_sel_o` out 4, `mem_wdata_o` out 32: bus request.
- `mem_ack_i` in 1, `mem_rdata_i` in 32: bus completion and read data.
- `stallreq_o` out 1: MEM-stage stall request to the controller.
- `misalign_o` out 1: a halfword/word access was misaligned; the access is suppressed.

## Operation
- Non-memory ops: all writeback fields pass through combinationally. Bus is idle; `stallreq_o` = 0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: for a memory op, `mem_req_o` = 1 combinationally. If `mem_ack_i` is high in the same cycle, the access completes, `stallreq_o` stays 0 and the state remains IDLE. Otherwise the next state is WAIT and `stallreq_o` = 1.
  - WAIT: `mem_req_o` = 1 with address/we/sel/wdata held stable; `stallreq_o` = !`mem_ack_i`. On ack: if `stall[4]` = NoStop, go to IDLE; else capture `mem_rdata_i` into `rdata_q` and go to DONE.
  - DONE: no request; the result comes from `rdata_q`; `stallreq_o` = 0. Go to IDLE on the first cycle with `stall[4]` = NoStop.
- Byte lanes are big-endian: `addr[1:0]` = 0 selects `sel` 4'b1000 / bits 31:24.
  - Loads: LB/LH sign-extend, LBU/LHU zero-extend; LW and LL take the full word.
  - Stores: the byte/halfword is replicated across all lanes; `mem_sel_o` marks the active lanes.
- Misalignment: LH/LHU/SH with `addr[0]` = 1, or LW/LL/SW/SC with `addr[1:0]` ≠ 0.
  - `misalign_o` = 1, no request is issued, `wreg_o` = 0.
- Link bit `llbit`:
  - Set to 1 when LL completes and advances.
  - Cleared when SC advances, or when `llbit_clear_i` is high. The clear wins over a simultaneous LL set.
  - SC with `llbit` = 1 stores and returns `wdata_o` = 1. SC with `llbit` = 0 issues no request and returns `wdata_o` = 0.

## Timing
- Reset (`rst` = 0), asynchronous:
  - state = IDLE, `llbit` = 0, `rdata_q` = 0.
  - Combinational outputs settle to zero / `Write_DIS`: `mem_req_o` = 0, `stallreq_o` = 0.
  - Reset during WAIT abandons the access; the bus must tolerate a dropped req.
- Zero-wait memory: 0 added cycles. N-cycle ack: `stallreq_o` is high for exactly N cycles.
- Ack and `llbit_clear_i` in the same cycle on an SC in WAIT: the store still completes and returns 1; `llbit` ends at 0.
- `mem_ack_i` is ignored in IDLE with no memory op and in DONE.

## Structure
- Add aluop codes for LB…SC and `Stall_Bus` indices to `risc32_instructions.v`/`risc32_consts.v`.
- Add FSM state constants to `risc32_consts.v`.
- One sub-module: `risc32_mem_align`, combinational lane select, sign-extension and sel generation.

## Test plan
- LW at `0x100`, ack same cycle, rdata `0xDEADBEEF` -> `wdata_o` = `0xDEADBEEF`, `stallreq_o` never 1.
- LB at `0x101`, rdata `0x1280FF00`, ack after 3 cycles -> `stallreq_o` high 3 cycles, `wdata_o` = `0xFFFFFF80`; LBU gives `0x00000080`.
- SH `0xABCD` at `0x202` -> `mem_sel_o` = 4'b0011, `mem_wdata_o` = `0xABCDABCD`, `mem_we_o` = 1.
- LL `0x300` then SC `0x300` -> store issued, `wdata_o` = 1. Repeat with `llbit_clear_i` pulsed between -> no req, `wdata_o` = 0.
- LW at `0x102` -> `misalign_o` = 1, `mem_req_o` = 0, `wreg_o` = 0.
- `rst` low during WAIT, then release -> IDLE, `mem_req_o` = 0, `llbit` = 0; the next LW proceeds normally.
